mm_stream_ctrl: RTL and testbench
=================================

Name: mm_stream_ctrl

Overview:
Host-side sequencer that drives the matrix-multiplier core's load/drain protocol from the other end. It accepts one job command, pulses start with the matrix sizes, and streams operand lines into the core with valid. It then pulls result lines out of the core's output buffer with pull/empty and presents them on a ready/valid stream toward the AFU write path. It sits between the AFU read/write DMA engines and the multiplier top.

Parameters:
DATA_W, 1024, width of one data line (32 unum elements of 32 bits)
CNT_W, 32, width of the line counters
PULL_LAT, 1, cycles from mm_pull to mm_data_out valid (fixed 1 in this revision)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  job command present
cmd_ready  out  1  block idle and able to accept a command
cmd_size1  in  64  matrix 1 size, [31:0] rows, [63:32] columns
cmd_size2  in  64  matrix 2 size, [31:0] rows
cmd_in_lines  in  CNT_W  total operand lines to forward
cmd_out_lines  in  CNT_W  total result lines to drain
in_data  in  DATA_W  operand line from the read engine
in_valid  in  1  operand line valid
in_ready  out  1  operand line accepted this cycle when in_valid is also high
mm_start  out  1  one-cycle start pulse to the core
mm_size1  out  64  registered copy of cmd_size1
mm_size2  out  64  registered copy of cmd_size2
mm_data  out  DATA_W  operand line to the core
mm_valid  out  1  mm_data valid (the core has no backpressure)
mm_pull  out  1  read request to the core's output buffer
mm_data_out  in  DATA_W  result line, valid PULL_LAT cycles after mm_pull
mm_empty  in  1  core output buffer empty
mm_full  in  1  core initialisation finished (status only)
mm_finish  in  1  core computation finished (status only)
out_data  out  DATA_W  result line to the write engine
out_valid  out  1  result line valid
out_ready  in  1  write engine accepts the line
done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1. State = IDLE, counters = 0, skid buffer empty.
- rst asserted mid-job aborts immediately. In-flight pulled data is discarded, and no done pulse is issued.
- States: IDLE, START, LOAD, DRAIN, FINISH.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch sizes and line counts, then go to START.
  - If cmd_in_lines = 0 and cmd_out_lines = 0, go to START anyway.
- START:
  - mm_start = 1 for exactly one cycle; mm_size1/2 already hold the latched values.
  - Next state: LOAD if in_lines > 0, otherwise DRAIN.
- LOAD:
  - in_ready = 1 while in_cnt < in_lines.
  - On in_valid & in_ready, register mm_data <= in_data and mm_valid <= 1 the next cycle, so latency is 1. Otherwise mm_valid <= 0.
  - in_cnt increments per accepted line.
  - When the last line is accepted, go to DRAIN, or to FINISH if out_lines = 0.
- DRAIN:
  - mm_pull = 1 when !mm_empty, out_cnt_req < out_lines, and skid occupancy + outstanding pulls < 2.
  - mm_data_out is captured into a 2-entry skid FIFO PULL_LAT cycles after each pull.
  - out_valid = skid not empty; out_data = skid head.
  - Pop on out_valid & out_ready. out_cnt increments per pop.
  - Go to FINISH when out_cnt = out_lines.
  - mm_pull is never asserted while mm_empty = 1.
- FINISH: done = 1 for one cycle, then return to IDLE.
- Simultaneous capture and pop in the same cycle keeps occupancy unchanged. The skid FIFO never overflows.
- Sizes and counts are held constant for the whole job. A cmd_valid outside IDLE is ignored, since cmd_ready = 0.
- Counters are unsigned CNT_W bits; the comparisons are exact equality with the latched totals.
- mm_full and mm_finish do not gate the sequencing. They are exposed only through the block's debug counters, which are outside this spec.

Test Plan:
- Reset, then cmd with in_lines = 3 and out_lines = 2 -> mm_start high exactly 1 cycle after the command is accepted. Three mm_valid pulses carry in_data D0..D2, each 1 cycle after acceptance. Then two pulls, out_data R0, R1 in order, then done one cycle after the R1 pop.
- in_valid toggling 1,0,1,0,1 in LOAD -> mm_valid mirrors it delayed 1 cycle, and in_cnt reaches 3 only after the third accepted beat.
- out_ready held low in DRAIN with mm_empty = 0 -> at most 2 pulls issued, and mm_pull stays 0 afterwards. Releasing out_ready drains lines in order with no loss or duplication.
- mm_empty = 1 for 10 cycles in DRAIN -> mm_pull stays 0 throughout, and no out_valid appears.
- rst pulsed in the middle of LOAD after 1 of 4 lines -> all outputs return to reset values on the same edge, and cmd_ready = 1. A following job with in_lines = 1 and out_lines = 1 completes normally.
- Command with in_lines = 0 and out_lines = 0 -> mm_start pulse, then done 2 cycles later, with no mm_valid or mm_pull activity.

Source files
------------

// File: rtl/mm_stream_ctrl.sv
`timescale 1ns/1ps
// Host-side sequencer for the matrix-multiplier core: issues start, streams operand
// lines into the core, then pulls result lines out through a 2-entry skid buffer.
module mm_stream_ctrl #(
    parameter int unsigned DATA_W   = 1024,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PULL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [63:0]       cmd_size1,
    input  logic [63:0]       cmd_size2,
    input  logic [CNT_W-1:0]  cmd_in_lines,
    input  logic [CNT_W-1:0]  cmd_out_lines,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mm_start,
    output logic [63:0]       mm_size1,
    output logic [63:0]       mm_size2,
    output logic [DATA_W-1:0] mm_data,
    output logic              mm_valid,
    output logic              mm_pull,
    input  logic [DATA_W-1:0] mm_data_out,
    input  logic              mm_empty,
    input  logic              mm_full,
    input  logic              mm_finish,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    typedef enum logic [2:0] {StIdle, StStart, StLoad, StDrain, StFinish} state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic [CNT_W-1:0]    in_lines_q;
    logic [CNT_W-1:0]    out_lines_q;
    logic [CNT_W-1:0]    in_cnt_q;
    logic [CNT_W-1:0]    out_req_q;
    logic [CNT_W-1:0]    out_cnt_q;
    logic [CNT_W-1:0]    in_cnt_inc;
    logic [CNT_W-1:0]    out_cnt_inc;

    logic [DATA_W-1:0]   skid_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          occ_q;
    logic [PULL_LAT-1:0] pull_pipe_q;
    logic [2:0]          inflight;

    logic in_fire;
    logic pop;
    logic capture;
    logic drain_last;

    // Status inputs do not affect sequencing.
    logic unused_status;
    assign unused_status = mm_full ^ mm_finish;

    assign in_cnt_inc  = in_cnt_q + CntOne;
    assign out_cnt_inc = out_cnt_q + CntOne;

    assign in_ready  = (state_q == StLoad) && (in_cnt_q != in_lines_q);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = skid_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign capture   = pull_pipe_q[PULL_LAT-1];

    // Buffered lines plus pulls still in flight must fit in the skid buffer.
    always_comb begin
        inflight = {1'b0, occ_q};
        for (int i = 0; i < PULL_LAT; i++) begin
            inflight = inflight + {2'b00, pull_pipe_q[i]};
        end
    end

    assign mm_pull = (state_q == StDrain) && !mm_empty && (out_req_q != out_lines_q) &&
                     (inflight < 3'd2);

    assign drain_last = (out_cnt_q == out_lines_q) || (pop && (out_cnt_inc == out_lines_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            in_lines_q  <= '0;
            out_lines_q <= '0;
            in_cnt_q    <= '0;
            out_req_q   <= '0;
            out_cnt_q   <= '0;
            cmd_ready   <= 1'b1;
            mm_start    <= 1'b0;
            mm_size1    <= '0;
            mm_size2    <= '0;
            mm_data     <= '0;
            mm_valid    <= 1'b0;
            done        <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            mm_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        mm_size1    <= cmd_size1;
                        mm_size2    <= cmd_size2;
                        in_lines_q  <= cmd_in_lines;
                        out_lines_q <= cmd_out_lines;
                        in_cnt_q    <= '0;
                        out_req_q   <= '0;
                        out_cnt_q   <= '0;
                        cmd_ready   <= 1'b0;
                        mm_start    <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    state_q <= (in_lines_q != '0) ? StLoad : StDrain;
                end
                StLoad: begin
                    if (in_fire) begin
                        mm_data  <= in_data;
                        mm_valid <= 1'b1;
                        in_cnt_q <= in_cnt_inc;
                        if (in_cnt_inc == in_lines_q) begin
                            if (out_lines_q == '0) begin
                                done    <= 1'b1;
                                state_q <= StFinish;
                            end else begin
                                state_q <= StDrain;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (mm_pull) begin
                        out_req_q <= out_req_q + CntOne;
                    end
                    if (pop) begin
                        out_cnt_q <= out_cnt_inc;
                    end
                    if (drain_last) begin
                        done    <= 1'b1;
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Skid buffer and pull-latency pipeline; reset drops any in-flight data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            pull_pipe_q <= '0;
        end else begin
            pull_pipe_q[0] <= mm_pull;
            for (int i = 1; i < PULL_LAT; i++) begin
                pull_pipe_q[i] <= pull_pipe_q[i-1];
            end
            if (capture) begin
                skid_q[wr_ptr_q] <= mm_data_out;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (capture && !pop) begin
                occ_q <= occ_q + 2'd1;
            end else if (!capture && pop) begin
                occ_q <= occ_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mm_stream_ctrl.sv
`timescale 1ns/1ps
// Directed bench for mm_stream_ctrl with a small behavioural model of the core's
// output buffer (one-cycle pull latency).
module tb_mm_stream_ctrl;

    localparam int unsigned DATA_W = 1024;
    localparam int unsigned CNT_W  = 32;
    localparam logic [63:0] DTAG   = 64'hD0D0_0000_0000_0000;
    localparam logic [63:0] RTAG   = 64'hEEEE_0000_0000_0000;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [63:0]       cmd_size1;
    logic [63:0]       cmd_size2;
    logic [CNT_W-1:0]  cmd_in_lines;
    logic [CNT_W-1:0]  cmd_out_lines;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mm_start;
    logic [63:0]       mm_size1;
    logic [63:0]       mm_size2;
    logic [DATA_W-1:0] mm_data;
    logic              mm_valid;
    logic              mm_pull;
    logic [DATA_W-1:0] mm_data_out;
    logic              mm_empty;
    logic              mm_full;
    logic              mm_finish;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    int          nvec;
    int          nerr;
    int          avail;
    int          n_pull;
    int          n_pull_empty;
    int          n_valid;
    int          exp_res;
    logic [63:0] res_idx;

    mm_stream_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_size1     (cmd_size1),
        .cmd_size2     (cmd_size2),
        .cmd_in_lines  (cmd_in_lines),
        .cmd_out_lines (cmd_out_lines),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mm_start      (mm_start),
        .mm_size1      (mm_size1),
        .mm_size2      (mm_size2),
        .mm_data       (mm_data),
        .mm_valid      (mm_valid),
        .mm_pull       (mm_pull),
        .mm_data_out   (mm_data_out),
        .mm_empty      (mm_empty),
        .mm_full       (mm_full),
        .mm_finish     (mm_finish),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input logic [63:0] t);
        return {16{t}};
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h required %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    // Step to the middle of the next cycle, clear of both clock edges.
    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic start_job(input int nin, input int nout, input logic [63:0] s1,
                             input logic [63:0] s2);
        cmd_size1     = s1;
        cmd_size2     = s2;
        cmd_in_lines  = nin;
        cmd_out_lines = nout;
        cmd_valid     = 1'b1;
        chk_bit("cmd_ready_idle", cmd_ready, 1'b1);
        cyc();
        cmd_valid = 1'b0;
        chk_bit("mm_start_pulse", mm_start, 1'b1);
        chk_bit("cmd_ready_busy", cmd_ready, 1'b0);
        chk_word("mm_size1", mm_size1, s1);
        chk_word("mm_size2", mm_size2, s2);
    endtask

    // From START: feed one operand line and land in DRAIN.
    task automatic load_one(input int beat);
        in_valid = 1'b1;
        in_data  = pat(DTAG + 64'(beat));
        cyc();
        chk_bit("mm_start_drop", mm_start, 1'b0);
        chk_bit("in_ready_load", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk_bit("mm_valid_one", mm_valid, 1'b1);
        chk_line("mm_data_one", mm_data, pat(DTAG + 64'(beat)));
        chk_bit("in_ready_drain", in_ready, 1'b0);
    endtask

    task automatic drain(input int n);
        int got;
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                chk_line("out_data", out_data, pat(RTAG + 64'(exp_res)));
                exp_res++;
                got++;
                if (got == n) break;
            end
            cyc();
        end
        chk_int("drain_count", got, n);
        cyc();
        chk_bit("done_pulse", done, 1'b1);
        out_ready = 1'b0;
        cyc();
        chk_bit("done_clear", done, 1'b0);
        chk_bit("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    // Core output buffer: data for a pull appears on the following cycle.
    initial begin : core_model
        logic pend;
        pend        = 1'b0;
        mm_data_out = '0;
        mm_empty    = 1'b1;
        forever begin
            @(negedge clk);
            if (pend) begin
                mm_data_out = pat(RTAG + res_idx);
                res_idx     = res_idx + 64'd1;
            end
            mm_empty = (avail <= 0);
            #1;
            pend = mm_pull;
            if (mm_pull) begin
                n_pull++;
                if (mm_empty) n_pull_empty++;
                avail--;
            end
            if (mm_valid) n_valid++;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic tog [5];
        int   beat;
        tog = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        nvec = 0; nerr = 0; avail = 0; n_pull = 0; n_pull_empty = 0; n_valid = 0;
        exp_res = 0; res_idx = 64'd0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_size1 = '0; cmd_size2 = '0;
        cmd_in_lines = '0; cmd_out_lines = '0; in_data = '0; in_valid = 1'b0;
        mm_full = 1'b0; mm_finish = 1'b0; out_ready = 1'b0;

        cyc();
        chk_bit("rst_cmd_ready", cmd_ready, 1'b1);
        chk_bit("rst_mm_start", mm_start, 1'b0);
        chk_bit("rst_mm_valid", mm_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_mm_pull", mm_pull, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_word("rst_mm_size1", mm_size1, 64'd0);
        chk_line("rst_out_data", out_data, '0);
        cyc();
        rst = 1'b0;
        cyc();

        // Job 1: three operand lines with in_valid toggling, two result lines.
        avail = 2; n_pull = 0; n_valid = 0;
        start_job(3, 2, 64'h0000_0004_0000_0003, 64'h0000_0000_0000_0004);
        in_valid = 1'b1;
        in_data  = pat(DTAG);
        cyc();
        chk_bit("start_no_accept", mm_valid, 1'b0);
        beat = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = tog[i];
            in_data  = pat(DTAG + 64'(beat));
            chk_bit("in_ready_toggle", in_ready, 1'b1);
            cyc();
            chk_bit("mm_valid_mirror", mm_valid, tog[i]);
            if (tog[i]) begin
                chk_line("mm_data_beat", mm_data, pat(DTAG + 64'(beat)));
                beat++;
            end
        end
        in_valid = 1'b0;
        chk_bit("in_ready_after3", in_ready, 1'b0);
        drain(2);
        chk_int("job1_pulls", n_pull, 2);
        chk_int("job1_valids", n_valid, 3);

        // Job 2: backpressure in DRAIN limits pulls to the skid depth.
        avail = 4; n_pull = 0;
        start_job(1, 4, 64'h0000_0001_0000_0001, 64'h0000_0000_0000_0001);
        load_one(10);
        for (int i = 0; i < 8; i++) cyc();
        chk_int("bp_pulls", n_pull, 2);
        chk_bit("bp_mm_pull", mm_pull, 1'b0);
        chk_bit("bp_out_valid", out_valid, 1'b1);
        chk_line("bp_head", out_data, pat(RTAG + 64'(exp_res)));
        drain(4);
        chk_int("bp_total_pulls", n_pull, 4);

        // Job 3: core buffer empty for 10 cycles in DRAIN.
        avail = 0; n_pull = 0;
        start_job(1, 1, 64'h0000_0002_0000_0002, 64'h0000_0000_0000_0002);
        load_one(20);
        for (int i = 0; i < 10; i++) begin
            chk_bit("empty_no_pull", mm_pull, 1'b0);
            chk_bit("empty_no_out", out_valid, 1'b0);
            cyc();
        end
        chk_int("empty_pulls", n_pull, 0);
        avail = 1;
        drain(1);

        // Job 4: reset in the middle of LOAD aborts on the same edge.
        avail = 0;
        start_job(4, 2, 64'h0000_0005_0000_0004, 64'h0000_0000_0000_0005);
        in_valid = 1'b1;
        in_data  = pat(DTAG + 64'd30);
        cyc();
        cyc();
        in_valid = 1'b0;
        chk_bit("pre_rst_mm_valid", mm_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk_bit("arst_cmd_ready", cmd_ready, 1'b1);
        chk_bit("arst_mm_valid", mm_valid, 1'b0);
        chk_bit("arst_in_ready", in_ready, 1'b0);
        chk_word("arst_mm_size1", mm_size1, 64'd0);
        chk_line("arst_mm_data", mm_data, '0);
        chk_bit("arst_done", done, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        // Job 5: normal job after the abort.
        avail = 1; n_pull = 0;
        start_job(1, 1, 64'h0000_0003_0000_0003, 64'h0000_0000_0000_0003);
        load_one(40);
        drain(1);
        chk_int("job5_pulls", n_pull, 1);

        // Job 6: zero-length job still pulses start and done.
        n_pull = 0; n_valid = 0;
        start_job(0, 0, 64'h0000_0007_0000_0007, 64'h0000_0000_0000_0007);
        cyc();
        chk_bit("zero_done_early", done, 1'b0);
        cyc();
        chk_bit("zero_done", done, 1'b1);
        cyc();
        chk_bit("zero_idle", cmd_ready, 1'b1);
        chk_int("zero_valids", n_valid, 0);
        chk_int("zero_pulls", n_pull, 0);
        chk_int("pull_while_empty", n_pull_empty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
